p_register_pattern_detect_simd: RTL and testbench



---
 rtl/p_register_pattern_detect_simd_if.sv | 23 ++
 rtl/p_register_pattern_detect_simd.sv | 54 +++++
 tb/tb_p_register_pattern_detect_simd.sv | 112 +++++++++++
 3 files changed

// File: rtl/p_register_pattern_detect_simd_if.sv
// p_register_pattern_detect_simd_if: P-stage operand, control and flag bundle
interface p_register_pattern_detect_simd_if #(parameter int WIDTH = 32);
  logic             CEP;
  logic [1:0]       USE_SIMD;
  logic [WIDTH-1:0] S;
  logic [3:0]       result_SIMD_carry_out;
  logic [WIDTH-1:0] PATTERN;
  logic [WIDTH-1:0] MASK;
  logic [WIDTH-1:0] P;
  logic [3:0]       CARRYOUT;
  logic [3:0]       PATTERNDETECT;
  logic [3:0]       PATTERNBDETECT;
  logic [3:0]       OVERFLOW;
  logic [3:0]       UNDERFLOW;
  modport master (
    output CEP, USE_SIMD, S, result_SIMD_carry_out, PATTERN, MASK,
    input  P, CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input  CEP, USE_SIMD, S, result_SIMD_carry_out, PATTERN, MASK,
    output P, CARRYOUT, PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/p_register_pattern_detect_simd.sv
// p_register_pattern_detect_simd: P register with SIMD-grouped masked pattern detect and overflow/underflow flags
module p_register_pattern_detect_simd #(
  parameter int WIDTH         = 32,
  parameter bit PATTERN_RESET = 1'b0
) (
  input logic clk,
  input logic reset,
  p_register_pattern_detect_simd_if.slave bus
);
  localparam int L = WIDTH / 4;
  logic [WIDTH-1:0] w_m, w_mb, r_p;
  logic [3:0] w_ml, w_mbl, w_pd, w_pbd, w_co;
  logic [3:0] r_co, r_pd, r_pbd, r_pdp, r_pbdp;
  function automatic logic [3:0] grp(input logic [1:0] mode, input logic [3:0] v);
    return mode == 2'b10 ? v :
           mode == 2'b01 ? {{2{&v[3:2]}}, {2{&v[1:0]}}} : {4{&v}};
  endfunction
  assign w_m  = bus.MASK | ~(bus.S ^ bus.PATTERN);
  assign w_mb = bus.MASK | (bus.S ^ bus.PATTERN);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign w_ml[l]  = &w_m[l*L +: L];
    assign w_mbl[l] = &w_mb[l*L +: L];
  end
  always_comb begin
    w_pd  = grp(bus.USE_SIMD, w_ml);
    w_pbd = grp(bus.USE_SIMD, w_mbl);
    w_co  = bus.USE_SIMD == 2'b10 ? bus.result_SIMD_carry_out :
            bus.USE_SIMD == 2'b01 ? {bus.result_SIMD_carry_out[3], 1'b0, bus.result_SIMD_carry_out[1], 1'b0} :
                                    {bus.result_SIMD_carry_out[3], 3'b000};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p    <= '0;
      r_co   <= '0;
      r_pd   <= '0;
      r_pbd  <= '0;
      r_pdp  <= {4{PATTERN_RESET}};
      r_pbdp <= {4{PATTERN_RESET}};
    end else if (bus.CEP) begin
      r_p    <= bus.S;
      r_co   <= w_co;
      r_pd   <= w_pd;
      r_pbd  <= w_pbd;
      r_pdp  <= r_pd;
      r_pbdp <= r_pbd;
    end
  end
  assign bus.P              = r_p;
  assign bus.CARRYOUT       = r_co;
  assign bus.PATTERNDETECT  = r_pd;
  assign bus.PATTERNBDETECT = r_pbd;
  assign bus.OVERFLOW       = r_pdp & ~r_pd & ~r_pbd;
  assign bus.UNDERFLOW      = r_pbdp & ~r_pd & ~r_pbd;
endmodule

// File: tb/tb_p_register_pattern_detect_simd.sv
// tb_p_register_pattern_detect_simd: directed vectors with hand-computed P, detect, carry and flag values
module tb_p_register_pattern_detect_simd;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_err = 0;
  p_register_pattern_detect_simd_if #(.WIDTH(32)) bus ();
  p_register_pattern_detect_simd #(.WIDTH(32), .PATTERN_RESET(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic flags(input string tag, input logic [3:0] pd, input logic [3:0] pbd, input logic [3:0] ov, input logic [3:0] un);
    check_eq({tag, "_pd"}, {28'd0, bus.PATTERNDETECT}, {28'd0, pd});
    check_eq({tag, "_pbd"}, {28'd0, bus.PATTERNBDETECT}, {28'd0, pbd});
    check_eq({tag, "_ovf"}, {28'd0, bus.OVERFLOW}, {28'd0, ov});
    check_eq({tag, "_unf"}, {28'd0, bus.UNDERFLOW}, {28'd0, un});
  endtask
  initial begin
    reset = 1'b1;
    bus.CEP = 1'b1;
    bus.USE_SIMD = 2'b00;
    bus.S = 32'hFFFF_FFFF;
    bus.result_SIMD_carry_out = 4'hF;
    bus.PATTERN = 32'h0;
    bus.MASK = 32'h0;
    tick();
    tick();
    check_eq("rst_p", bus.P, 32'h0);
    check_eq("rst_co", {28'd0, bus.CARRYOUT}, 32'h0);
    flags("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    bus.CEP = 1'b0;
    tick();
    check_eq("hold_p", bus.P, 32'h0);
    bus.CEP = 1'b1;
    tick();
    check_eq("load_p", bus.P, 32'hFFFF_FFFF);
    check_eq("co_m00", {28'd0, bus.CARRYOUT}, 32'h8);
    flags("ones", 4'h0, 4'hF, 4'h0, 4'h0);
    bus.MASK = 32'h0000_FFFF;
    bus.S = 32'h0000_1234;
    tick();
    flags("m00_pd", 4'hF, 4'h0, 4'h0, 4'h0);
    bus.S = 32'hFFFF_0000;
    tick();
    flags("m00_pbd", 4'h0, 4'hF, 4'h0, 4'h0);
    bus.USE_SIMD = 2'b10;
    bus.MASK = 32'h0;
    bus.S = 32'h00FF_0000;
    tick();
    flags("m10", 4'b1011, 4'b0100, 4'h0, 4'h0);
    check_eq("co_m10", {28'd0, bus.CARRYOUT}, 32'hF);
    bus.USE_SIMD = 2'b00;
    bus.MASK = 32'h3FFF_FFFF;
    bus.S = 32'h3FFF_FFFE;
    tick();
    flags("ovf_a", 4'hF, 4'h0, 4'h0, 4'h0);
    bus.S = 32'h8000_0001;
    tick();
    check_eq("ovf_p", bus.P, 32'h8000_0001);
    flags("ovf_b", 4'h0, 4'h0, 4'hF, 4'h0);
    bus.S = 32'h3FFF_FFFE;
    tick();
    flags("ovfg_a", 4'hF, 4'h0, 4'h0, 4'h0);
    bus.CEP = 1'b0;
    bus.S = 32'h0;
    tick();
    check_eq("ovfg_hold_p", bus.P, 32'h3FFF_FFFE);
    flags("ovfg_hold", 4'hF, 4'h0, 4'h0, 4'h0);
    bus.CEP = 1'b1;
    bus.S = 32'h8000_0001;
    tick();
    flags("ovfg_b", 4'h0, 4'h0, 4'hF, 4'h0);
    bus.USE_SIMD = 2'b01;
    bus.MASK = 32'h3FFF_3FFF;
    bus.S = 32'hC000_C000;
    tick();
    flags("unf_a", 4'h0, 4'hF, 4'h0, 4'h0);
    check_eq("co_m01", {28'd0, bus.CARRYOUT}, 32'hA);
    bus.S = 32'h7FFF_0000;
    tick();
    flags("unf_b", 4'b0011, 4'h0, 4'h0, 4'b1100);
    bus.USE_SIMD = 2'b11;
    bus.result_SIMD_carry_out = 4'hF;
    bus.MASK = 32'hFFFF_FFFF;
    bus.S = 32'h1234_5678;
    tick();
    check_eq("co_m11", {28'd0, bus.CARRYOUT}, 32'h8);
    flags("allmask", 4'hF, 4'hF, 4'h0, 4'h0);
    bus.USE_SIMD = 2'b10;
    bus.result_SIMD_carry_out = 4'b0101;
    tick();
    check_eq("co_m10_mix", {28'd0, bus.CARRYOUT}, 32'h5);
    reset = 1'b1;
    bus.CEP = 1'b0;
    tick();
    check_eq("rst2_p", bus.P, 32'h0);
    check_eq("rst2_co", {28'd0, bus.CARRYOUT}, 32'h0);
    flags("rst2", 4'h0, 4'h0, 4'h0, 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
